// File: rtl/c2_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per clock, LSB first,
// with a registered carry between slices and a start/busy/done handshake.
module c2_serial_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT:0]   slice;
  logic             c_msb;
  logic             last_step;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] op_a_shift;
  logic [WIDTH-1:0] op_b_shift;

  always_comb begin
    slice = {1'b0, op_a_q[DIGIT-1:0]} + {1'b0, op_b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Sum bit = a ^ b ^ carry-in, so the carry into the slice MSB falls out of the XOR.
    c_msb     = slice[DIGIT-1] ^ op_a_q[DIGIT-1] ^ op_b_q[DIGIT-1];
    last_step = (cnt_q == CW'(STEPS - 1));
  end

  if (STEPS == 1) begin : g_single
    assign res_shift  = slice[DIGIT-1:0];
    assign op_a_shift = '0;
    assign op_b_shift = '0;
  end else begin : g_multi
    assign res_shift  = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    assign op_a_shift = {{DIGIT{1'b0}}, op_a_q[WIDTH-1:DIGIT]};
    assign op_b_shift = {{DIGIT{1'b0}}, op_b_q[WIDTH-1:DIGIT]};
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        op_a_d  = op_a_shift;
        op_b_d  = op_b_shift;
        res_d   = res_shift;
        carry_d = slice[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last_step) begin
          sum_d   = res_shift;
          cout_d  = slice[DIGIT];
          ovf_d   = c_msb ^ slice[DIGIT];
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_c2_serial_addsub.sv
// Scoreboard bench for c2_serial_addsub: directed vectors on a DIGIT=4 instance,
// plus random add/sub sweeps on DIGIT = 1, 2, 8, 16 instances against a reference model.
module tb_c2_serial_addsub;

  localparam int W     = 16;
  localparam int STEPS = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           launch_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic note_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Independent reference: full-width sum, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    logic [W:0]   full;
    logic [W-1:0] bb;
    exp_t         e;
    bb     = ms ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + (W+1)'(ms);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (ms) e.ovf = (ma[W-1] != mb[W-1]) && (e.sum[W-1] != ma[W-1]);
    else    e.ovf = (ma[W-1] == mb[W-1]) && (e.sum[W-1] != ma[W-1]);
    e.launch_cyc = 0;
    return e;
  endfunction

  // ---------------- main DUT (DIGIT=4) ----------------
  logic         rst   = 1'b1;
  logic         rst_s = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  c2_serial_addsub #(.WIDTH(W), .DIGIT(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  exp_t         exp_q[$];
  logic [W+1:0] prev_out;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_out = {cout, ovf, sum};
    end else begin
      check("done_busy_excl", 32'(done & busy), 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          note_fail("unexpected_done");
        end else begin
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("cout", 32'(cout), 32'(e.cout));
          check("ovf", 32'(ovf), 32'(e.ovf));
          check("latency", 32'(cyc - e.launch_cyc), 32'(STEPS));
        end
        prev_out = {cout, ovf, sum};
      end else begin
        check("out_hold", 32'({cout, ovf, sum}), 32'(prev_out));
      end
    end
  end

  task automatic launch_now(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                            input logic want, input logic [W-1:0] es, input logic ec,
                            input logic eo);
    exp_t e;
    a     = ta;
    b     = tb_;
    sub   = ts;
    start = 1'b1;
    if (want) begin
      e.sum        = es;
      e.cout       = ec;
      e.ovf        = eo;
      e.launch_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    sub   = 1'($urandom);
  endtask

  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input logic want, input logic [W-1:0] es, input logic ec,
                        input logic eo);
    @(negedge clk);
    launch_now(ta, tb_, ts, want, es, ec, eo);
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      @(negedge clk);
    end
    note_fail(name);
  endtask

  // ---------------- DIGIT sweep instances ----------------
  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int DIG = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    localparam int ST  = W / DIG;

    logic         s_start = 1'b0;
    logic         s_sub   = 1'b0;
    logic [W-1:0] s_a     = '0;
    logic [W-1:0] s_b     = '0;
    logic         s_busy, s_done, s_cout, s_ovf;
    logic [W-1:0] s_sum;
    logic         fin = 1'b0;
    exp_t         q[$];

    c2_serial_addsub #(.WIDTH(W), .DIGIT(DIG)) u_dut (
      .clk  (clk),
      .rst  (rst_s),
      .start(s_start),
      .sub  (s_sub),
      .a    (s_a),
      .b    (s_b),
      .busy (s_busy),
      .done (s_done),
      .sum  (s_sum),
      .cout (s_cout),
      .ovf  (s_ovf)
    );

    always @(negedge clk) begin
      exp_t e;
      if (!rst_s && s_done) begin
        if (q.size() == 0) begin
          note_fail($sformatf("sweep%0d_unexpected_done", DIG));
        end else begin
          e = q.pop_front();
          check($sformatf("sweep%0d_sum", DIG), 32'(s_sum), 32'(e.sum));
          check($sformatf("sweep%0d_cout", DIG), 32'(s_cout), 32'(e.cout));
          check($sformatf("sweep%0d_ovf", DIG), 32'(s_ovf), 32'(e.ovf));
          check($sformatf("sweep%0d_latency", DIG), 32'(cyc - e.launch_cyc), 32'(ST));
        end
      end
    end

    initial begin
      exp_t         e;
      logic [W-1:0] ra, rb;
      logic         rs;
      wait (rst_s == 1'b0);
      @(negedge clk);
      for (int n = 0; n < 1000; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        if (n % 5 == 0) ra = {ra[W-1], {(W-1){~ra[W-1]}}};
        if (n % 7 == 0) rb = {rb[W-1], {(W-1){~rb[W-1]}}};
        s_a     = ra;
        s_b     = rb;
        s_sub   = rs;
        s_start = 1'b1;
        e = model(ra, rb, rs);
        e.launch_cyc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 0; k < ST + 4 && !s_done; k++) @(negedge clk);
        if (!s_done) note_fail($sformatf("sweep%0d_timeout", DIG));
      end
      fin = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vs;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst   = 1'b0;
    rst_s = 1'b0;

    // Basic add with exact latency / pulse-width checks
    launch(16'h1234, 16'h0FCD, 1'b0, 1'b1, 16'h2201, 1'b0, 1'b0);
    for (int k = 0; k < STEPS; k++) begin
      check("lat_busy", 32'(busy), 32'd1);
      check("lat_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    check("lat_done", 32'(done), 32'd1);
    check("lat_done_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // Carry / overflow / borrow boundaries
    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].va, vecs[i].vb, vecs[i].vs, 1'b1, vecs[i].es, vecs[i].ec, vecs[i].eo);
      wait_done("vec_timeout", 10);
    end

    // start during RUN is ignored
    launch(16'h1111, 16'h2222, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
    a     = 16'hFFFF;
    b     = 16'hFFFF;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_timeout", 10);
    repeat (3) @(negedge clk);
    check("no_restart", 32'(busy), 32'd0);

    // Back-to-back launch in the DONE cycle
    launch(16'h0100, 16'h0200, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0);
    wait_done("b2b_first_timeout", 10);
    launch_now(16'hA000, 16'h1000, 1'b1, 1'b1, 16'h9000, 1'b1, 1'b0);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_sum_hold", 32'(sum), 32'h0300);
    wait_done("b2b_second_timeout", 10);

    // Asynchronous reset two cycles into RUN aborts the operation
    launch(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    launch(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    wait_done("post_reset_timeout", 10);
    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Wait for the DIGIT sweeps
    for (int i = 0; i < 40000; i++) begin
      if (g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin) break;
      @(negedge clk);
    end
    if (!(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin && g_sweep[3].fin))
      note_fail("sweep_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
